// File: rtl/batch_sequencer.sv
// Batch sequencer: streams 8-word batches through load / execute / store.
// Optional BATCH_SEQ_PAUSE_EN adds a pause input honoured between batches.
module batch_sequencer #(
   parameter int unsigned MEM_LAT = 1,
   parameter int unsigned OP_LAT  = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
`ifdef BATCH_SEQ_PAUSE_EN
   input  logic       pause,
`endif
   input  logic [3:0] num_batches,
   output logic [5:0] AddrReading,
   output logic [5:0] AddrWriting,
   output logic [2:0] RegIndex,
   output logic       EnableInputMEM,
   output logic       EnableReg,
   output logic       EnableOperation,
   output logic       EnableOutputMEM,
   output logic       busy,
   output logic       Done
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      WAIT_LD = 3'd2,
      EXEC    = 3'd3,
      WAIT_OP = 3'd4,
      STORE   = 3'd5,
`ifdef BATCH_SEQ_PAUSE_EN
      PAUSE   = 3'd7,
`endif
      DONE    = 3'd6
   } state_t;

   localparam int          OL_M2I = (OP_LAT > 1) ? int'(OP_LAT) - 2 : 0;
   localparam logic [1:0]  ML_M1  = 2'(MEM_LAT - 1);
   localparam logic [1:0]  OL_M2  = 2'(OL_M2I);

   state_t                   state_q, state_d;
   logic [2:0]               word_q, word_d;
   logic [2:0]               b_q, b_d;
   logic [3:0]               n_q, n_d;
   logic [1:0]               cnt_q, cnt_d;

   logic                     rd_en_q, rd_en_d;
   logic                     op_en_q, op_en_d;
   logic                     wr_en_q, wr_en_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic [5:0]               addr_rd_q, addr_rd_d;
   logic [5:0]               addr_wr_q, addr_wr_d;

   // Read-to-regfile delay line; index stages hold their last valid word
   logic [MEM_LAT-1:0]       dv_q;
   logic [MEM_LAT-1:0][2:0]  di_q;

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      b_d     = b_q;
      n_d     = n_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               n_d    = (num_batches > 4'd8) ? 4'd8 : num_batches;
               b_d    = 3'd0;
               word_d = 3'd0;
               state_d = (n_d == 4'd0) ? DONE : LOAD;
            end
         end
         LOAD: begin
            if (word_q == 3'd7) begin
               state_d = WAIT_LD;
               cnt_d   = ML_M1;
            end else begin
               word_d = word_q + 3'd1;
            end
         end
         WAIT_LD: begin
            if (cnt_q == 2'd0) state_d = EXEC;
            else               cnt_d   = cnt_q - 2'd1;
         end
         EXEC: begin
            if (OP_LAT == 1) begin
               state_d = STORE;
            end else begin
               state_d = WAIT_OP;
               cnt_d   = OL_M2;
            end
         end
         WAIT_OP: begin
            if (cnt_q == 2'd0) state_d = STORE;
            else               cnt_d   = cnt_q - 2'd1;
         end
         STORE: begin
            if (({1'b0, b_q} + 4'd1) < n_q) begin
               b_d     = b_q + 3'd1;
               word_d  = 3'd0;
               state_d = LOAD;
`ifdef BATCH_SEQ_PAUSE_EN
               if (pause) state_d = PAUSE;
`endif
            end else begin
               state_d = DONE;
            end
         end
`ifdef BATCH_SEQ_PAUSE_EN
         PAUSE: begin
            if (!pause) state_d = LOAD;
         end
`endif
         default: state_d = IDLE;
      endcase

      // Strobes are registered from the state being entered
      rd_en_d   = (state_d == LOAD);
      op_en_d   = (state_d == EXEC);
      wr_en_d   = (state_d == STORE);
      done_d    = (state_d == DONE);
      busy_d    = (state_d != IDLE) && (state_d != DONE);
      addr_rd_d = rd_en_d ? {b_d, word_d} : addr_rd_q;
      addr_wr_d = wr_en_d ? {3'b000, b_d} : addr_wr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         word_q    <= 3'd0;
         b_q       <= 3'd0;
         n_q       <= 4'd0;
         cnt_q     <= 2'd0;
         rd_en_q   <= 1'b0;
         op_en_q   <= 1'b0;
         wr_en_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         addr_rd_q <= 6'd0;
         addr_wr_q <= 6'd0;
         dv_q      <= '0;
         di_q      <= '0;
      end else begin
         state_q   <= state_d;
         word_q    <= word_d;
         b_q       <= b_d;
         n_q       <= n_d;
         cnt_q     <= cnt_d;
         rd_en_q   <= rd_en_d;
         op_en_q   <= op_en_d;
         wr_en_q   <= wr_en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         addr_rd_q <= addr_rd_d;
         addr_wr_q <= addr_wr_d;
         for (int k = int'(MEM_LAT) - 1; k > 0; k--) begin
            dv_q[k] <= dv_q[k-1];
            if (dv_q[k-1]) di_q[k] <= di_q[k-1];
         end
         dv_q[0] <= rd_en_q;
         if (rd_en_q) di_q[0] <= addr_rd_q[2:0];
      end
   end

   assign AddrReading     = addr_rd_q;
   assign AddrWriting     = addr_wr_q;
   assign RegIndex        = di_q[MEM_LAT-1];
   assign EnableInputMEM  = rd_en_q;
   assign EnableReg       = dv_q[MEM_LAT-1];
   assign EnableOperation = op_en_q;
   assign EnableOutputMEM = wr_en_q;
   assign busy            = busy_q;
   assign Done            = done_q;

endmodule

// File: tb/tb_batch_sequencer.sv
// Randomized bench for batch_sequencer: two latency configurations run in
// lockstep against a per-cycle event-list model of each run.
module tb_batch_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] num_batches;
`ifdef BATCH_SEQ_PAUSE_EN
   logic       pause;
`endif

   logic [5:0] ar0, aw0, ar1, aw1;
   logic [2:0] ri0, ri1;
   logic       ei0, er0, eo0, ew0, bz0, dn0;
   logic       ei1, er1, eo1, ew1, bz1, dn1;
   logic [20:0] obs0, obs1;

   int checks   = 0;
   int failures = 0;

   logic [20:0] exp_q [2][256];
   logic [5:0]  h_ar [2];
   logic [5:0]  h_aw [2];
   logic [2:0]  h_ri [2];

   always #5 clk = ~clk;

   batch_sequencer u0 (
      .clk(clk), .rst(rst), .start(start),
`ifdef BATCH_SEQ_PAUSE_EN
      .pause(pause),
`endif
      .num_batches(num_batches),
      .AddrReading(ar0), .AddrWriting(aw0), .RegIndex(ri0),
      .EnableInputMEM(ei0), .EnableReg(er0),
      .EnableOperation(eo0), .EnableOutputMEM(ew0),
      .busy(bz0), .Done(dn0)
   );

   batch_sequencer #(.MEM_LAT(2), .OP_LAT(3)) u1 (
      .clk(clk), .rst(rst), .start(start),
`ifdef BATCH_SEQ_PAUSE_EN
      .pause(pause),
`endif
      .num_batches(num_batches),
      .AddrReading(ar1), .AddrWriting(aw1), .RegIndex(ri1),
      .EnableInputMEM(ei1), .EnableReg(er1),
      .EnableOperation(eo1), .EnableOutputMEM(ew1),
      .busy(bz1), .Done(dn1)
   );

   assign obs0 = {bz0, dn0, ew0, eo0, er0, ei0, ri0, aw0, ar0};
   assign obs1 = {bz1, dn1, ew1, eo1, er1, ei1, ri1, aw1, ar1};

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Expected outputs per cycle after start, from batch timing rules
   task automatic build(input int u, input int ml, input int ol,
                        input int n, input int gap, output int dstart);
      bit         ei [256];
      bit         er [256];
      bit         eo [256];
      bit         ew [256];
      logic [5:0] ra [256];
      logic [5:0] wa [256];
      logic [2:0] ri [256];
      logic [5:0] car, caw;
      logic [2:0] cri;
      int per, base;
      per  = 10 + ml + ol - 1;
      base = 0;
      for (int r = 0; r < 256; r++) begin
         ei[r] = 0; er[r] = 0; eo[r] = 0; ew[r] = 0;
         ra[r] = 0; wa[r] = 0; ri[r] = 0;
      end
      for (int b = 0; b < n; b++) begin
         for (int i = 0; i < 8; i++) begin
            ei[base+i]    = 1;
            ra[base+i]    = 6'(8 * b + i);
            er[base+i+ml] = 1;
            ri[base+i+ml] = 3'(i);
         end
         eo[base+8+ml]    = 1;
         ew[base+8+ml+ol] = 1;
         wa[base+8+ml+ol] = 6'(b);
         base += per + ((b == 0 && n > 1) ? gap : 0);
      end
      dstart = base;
      car = h_ar[u]; caw = h_aw[u]; cri = h_ri[u];
      for (int r = 0; r < 256; r++) begin
         if (ei[r]) car = ra[r];
         if (ew[r]) caw = wa[r];
         if (er[r]) cri = ri[r];
         exp_q[u][r] = {(r < dstart), (r >= dstart), ew[r], eo[r],
                        er[r], ei[r], cri, caw, car};
      end
      h_ar[u] = car; h_aw[u] = caw; h_ri[u] = cri;
   endtask

   task automatic run(input int nb, input int pz, input int junk,
                      input int rst_at);
      int n, d0, d1, len, dmin;
      n = (nb > 8) ? 8 : nb;
      build(0, 1, 1, n, (pz != 0) ? 3 : 0, d0);
      build(1, 2, 3, n, (pz != 0) ? 1 : 0, d1);
      len  = ((d0 > d1) ? d0 : d1) + 3;
      dmin = (d0 < d1) ? d0 : d1;
      start = 1'b1;
      num_batches = 4'(nb);
      @(negedge clk);
      start = 1'b0;
      for (int r = 0; r < len; r++) begin
         check($sformatf("u0_n%0d_r%0d", nb, r), 32'(obs0), 32'(exp_q[0][r]));
         check($sformatf("u1_n%0d_r%0d", nb, r), 32'(obs1), 32'(exp_q[1][r]));
         if (r == rst_at) begin
            rst = 1'b1;
            start = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            start = 1'b0;
            for (int u = 0; u < 2; u++) begin
               h_ar[u] = 0; h_aw[u] = 0; h_ri[u] = 0;
            end
            check("abort_u0", 32'(obs0), 32'd0);
            check("abort_u1", 32'(obs1), 32'd0);
            @(negedge clk);
            check("idle_u0", 32'(obs0), 32'd0);
            check("idle_u1", 32'(obs1), 32'd0);
            return;
         end
         if (junk != 0 && r < dmin && $urandom_range(3) == 0) begin
            start = 1'b1;
            num_batches = 4'($urandom_range(15));
         end
`ifdef BATCH_SEQ_PAUSE_EN
         pause = (pz != 0) && (r >= 8) && (r <= 12);
`endif
         @(negedge clk);
         start = 1'b0;
      end
`ifdef BATCH_SEQ_PAUSE_EN
      pause = 1'b0;
`endif
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      num_batches = 4'd0;
`ifdef BATCH_SEQ_PAUSE_EN
      pause = 1'b0;
`endif
      for (int u = 0; u < 2; u++) begin
         h_ar[u] = 0; h_aw[u] = 0; h_ri[u] = 0;
      end
      repeat (2) @(negedge clk);
      check("reset_u0", 32'(obs0), 32'd0);
      check("reset_u1", 32'(obs1), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle0_u0", 32'(obs0), 32'd0);
      check("idle0_u1", 32'(obs1), 32'd0);

      run(1, 0, 0, -1);
      run(8, 0, 0, -1);
      run(12, 0, 0, -1);
      run(0, 0, 0, -1);
      run(1, 0, 0, 4);
      run(3, 0, 0, -1);
`ifdef BATCH_SEQ_PAUSE_EN
      run(2, 1, 0, -1);
`endif
      repeat (16) run($urandom_range(15), 0, 1, -1);
      run($urandom_range(8, 1), 0, 1, $urandom_range(6));
      repeat (4) run($urandom_range(15), 0, 1, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
